// File: rtl/gate_truth_checker.sv
// gate_truth_checker
//
// Stimulus/response stage wrapped around a 2-input gate under test. A run
// steps {a_out,b_out} through 00, 01, 10, 11. Each vector is held for
// SETTLE_CYCLES DRIVE cycles and then one SAMPLE cycle. The gate output
// y_in is compared against EXP_TT[{a,b}] at the closing edge of SAMPLE.
// Mismatches accumulate in fail_mask. pass is raised when a run ends with
// no mismatches.
//
// Handshake: start is a level sampled only while the FSM is IDLE. A
// start seen in any other state is dropped, not queued. There is no ready
// signal; busy=1 tells the driver that a start would be ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request a full 4-vector check (sampled in IDLE only)
//   y_in       output of the gate under test
//   a_out      drives gate input a
//   b_out      drives gate input b
//   busy       high from the first DRIVE cycle through the DONE cycle
//   done       one-cycle pulse when all four vectors have been checked
//   pass       1 when the last completed run had fail_mask == 0
//   fail_mask  bit i set if vector i mismatched
//   vec_idx    index of the vector currently (or last) driven
//   state_dbg  current FSM state encoding (IDLE=0, DRIVE=1, SAMPLE=2, DONE=3)
//
// Every output is a flop; nothing combinational reaches a port from
// y_in or start.

module gate_truth_checker #(
    parameter logic [3:0] EXP_TT        = 4'b0001,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [1:0] vec_idx,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // The counter value seen in the final DRIVE cycle of a vector.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic [1:0] vec_next;
    logic [3:0] fm_next;
    logic       pass_next;
    logic       drive_next;
    logic       a_next;
    logic       b_next;
    logic       busy_next;
    logic       done_next;

    // Next-state and next-datapath logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        vec_next   = vec_idx;
        fm_next    = fail_mask;
        pass_next  = pass;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = DRIVE;
                    cnt_next   = 4'd0;
                    vec_next   = 2'd0;
                    fm_next    = 4'b0000;
                    pass_next  = 1'b0;
                end
            end

            DRIVE: begin
                cnt_next = cnt + 4'd1;
                if (cnt == SETTLE_LAST) begin
                    state_next = SAMPLE;
                end
            end

            SAMPLE: begin
                if (y_in != EXP_TT[vec_idx]) begin
                    fm_next[vec_idx] = 1'b1;
                end
                if (vec_idx == 2'd3) begin
                    state_next = DONE;
                    // pass is computed here from the mask that already includes
                    // the vector-3 result. This makes it valid in the DONE
                    // cycle itself rather than one cycle later.
                    pass_next  = ~|fm_next;
                end else begin
                    state_next = DRIVE;
                    vec_next   = vec_idx + 2'd1;
                    cnt_next   = 4'd0;
                end
            end

            DONE: begin
                pass_next  = ~|fail_mask;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output values are decoded from the next state so that the registered
    // outputs line up with the state they describe.
    always_comb begin
        drive_next = (state_next == DRIVE) || (state_next == SAMPLE);
        a_next     = drive_next & vec_next[1];
        b_next     = drive_next & vec_next[0];
        busy_next  = (state_next != IDLE);
        done_next  = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            vec_idx   <= 2'd0;
            fail_mask <= 4'b0000;
            pass      <= 1'b0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            vec_idx   <= vec_next;
            fail_mask <= fm_next;
            pass      <= pass_next;
            a_out     <= a_next;
            b_out     <= b_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker. It runs three instances side by side:
//   u0: default NOR expectation, SETTLE_CYCLES=2
//   u1: NAND expectation (4'b0111), SETTLE_CYCLES=2
//   u2: NOR expectation, SETTLE_CYCLES=1
// A behavioural model predicts every output of every instance on every
// cycle. The model works from the run's start cycle and plain cycle
// arithmetic. The gate under test is a truth table captured when a run is
// accepted. y_in carries that table's value only in the predicted sample
// cycle and random noise everywhere else.

module tb_gate_truth_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    logic y_v      [3];
    logic a_o      [3];
    logic b_o      [3];
    logic busy_o   [3];
    logic done_o   [3];
    logic pass_o   [3];
    logic [3:0] fm_o  [3];
    logic [1:0] vec_o [3];
    logic [1:0] dbg_o [3];

    gate_truth_checker u0 (
        .clk(clk), .rst(rst), .start(start), .y_in(y_v[0]),
        .a_out(a_o[0]), .b_out(b_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .pass(pass_o[0]), .fail_mask(fm_o[0]), .vec_idx(vec_o[0]), .state_dbg(dbg_o[0])
    );

    gate_truth_checker #(.EXP_TT(4'b0111), .SETTLE_CYCLES(2)) u1 (
        .clk(clk), .rst(rst), .start(start), .y_in(y_v[1]),
        .a_out(a_o[1]), .b_out(b_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .pass(pass_o[1]), .fail_mask(fm_o[1]), .vec_idx(vec_o[1]), .state_dbg(dbg_o[1])
    );

    gate_truth_checker #(.EXP_TT(4'b0001), .SETTLE_CYCLES(1)) u2 (
        .clk(clk), .rst(rst), .start(start), .y_in(y_v[2]),
        .a_out(a_o[2]), .b_out(b_o[2]), .busy(busy_o[2]), .done(done_o[2]),
        .pass(pass_o[2]), .fail_mask(fm_o[2]), .vec_idx(vec_o[2]), .state_dbg(dbg_o[2])
    );

    // Per-instance configuration, mirrored from the parameter overrides above.
    int         settle_c [3] = '{2, 2, 1};
    logic [3:0] exp_c    [3] = '{4'b0001, 4'b0111, 4'b0001};
    string      name_c   [3] = '{"nor_s2", "nandexp_s2", "nor_s1"};

    // Model state.
    bit         has_run [3];
    int         k_run   [3];
    logic [3:0] tt_run  [3];
    logic [3:0] gate_tt;
    int         cyc;

    // Scoreboard counters.
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [10:0] got, input logic [10:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d {busy,done,pass,fail_mask,vec,a,b} got=%b want=%b",
                     tag, cyc, got, want);
        end
    endtask

    function automatic bit model_idle(input int n);
        int p;
        int len;
        len = settle_c[n] + 1;
        p   = cyc - (k_run[n] + 1);
        return !has_run[n] || (p > 4 * len);
    endfunction

    // Expected {busy,done,pass,fail_mask,vec_idx,a,b} for instance n in cycle cyc.
    function automatic logic [10:0] model_out(input int n);
        int         p;
        int         len;
        int         vi;
        logic [3:0] fm_final;
        logic [3:0] fm_part;
        logic [1:0] v;
        len      = settle_c[n] + 1;
        p        = cyc - (k_run[n] + 1);
        fm_final = tt_run[n] ^ exp_c[n];
        if (!has_run[n]) begin
            return 11'd0;
        end else if (p < 4 * len) begin
            vi      = p / len;
            v       = 2'(vi);
            // Only vectors sampled in earlier cycles are visible in the mask.
            fm_part = fm_final & 4'((1 << vi) - 1);
            return {1'b1, 1'b0, 1'b0, fm_part, v, v[1], v[0]};
        end else if (p == 4 * len) begin
            return {1'b1, 1'b1, ~|fm_final, fm_final, 2'd3, 2'b00};
        end else begin
            return {1'b0, 1'b0, ~|fm_final, fm_final, 2'd3, 2'b00};
        end
    endfunction

    // One clock cycle: check outputs, drive inputs, advance the model.
    task automatic tick(input logic st, input logic rs);
        int p;
        int len;
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            check_eq(name_c[n], {busy_o[n], done_o[n], pass_o[n], fm_o[n], vec_o[n], a_o[n], b_o[n]},
                     model_out(n));
        end
        start = st;
        rst   = rs;
        for (int n = 0; n < 3; n++) begin
            len = settle_c[n] + 1;
            p   = cyc - (k_run[n] + 1);
            if (has_run[n] && p >= 0 && p < 4 * len && (p % len) == settle_c[n]) begin
                y_v[n] = tt_run[n][p / len];
            end else begin
                y_v[n] = 1'($urandom_range(0, 1));
            end
        end
        for (int n = 0; n < 3; n++) begin
            if (rs) begin
                has_run[n] = 1'b0;
            end else if (st && model_idle(n)) begin
                has_run[n] = 1'b1;
                k_run[n]   = cyc;
                tt_run[n]  = gate_tt;
            end
        end
        cyc++;
    endtask

    task automatic idle_cycles(input int count);
        for (int i = 0; i < count; i++) tick(1'b0, 1'b0);
    endtask

    task automatic single_run(input logic [3:0] tt);
        gate_tt = tt;
        tick(1'b1, 1'b0);
        idle_cycles(18);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        gate_tt = 4'b0001;
        cyc     = 0;
        for (int n = 0; n < 3; n++) begin
            y_v[n]     = 1'b0;
            has_run[n] = 1'b0;
            k_run[n]   = 0;
            tt_run[n]  = 4'b0000;
        end
        repeat (2) @(negedge clk);

        // Reset state, held reset, then released.
        tick(1'b0, 1'b1);
        idle_cycles(2);

        // NOR gate, stuck-at-0 output, stuck-at-1 output.
        single_run(4'b0001);
        single_run(4'b0000);
        single_run(4'b1111);

        // Start re-pulsed at relative cycles 3 and 12 during a run, then at 14.
        gate_tt = 4'b0001;
        tick(1'b1, 1'b0);
        for (int t = 1; t < 40; t++) tick((t == 3) || (t == 12) || (t == 14), 1'b0);

        // Reset at relative cycle 7 mid-run, then a clean run.
        tick(1'b1, 1'b0);
        for (int t = 1; t < 12; t++) tick(1'b0, (t == 7));
        single_run(4'b0001);

        // A start in the same cycle as reset is ignored.
        tick(1'b1, 1'b1);
        idle_cycles(4);

        // Back-to-back runs: start held high continuously.
        gate_tt = 4'b0001;
        for (int t = 0; t < 30; t++) tick(1'b1, 1'b0);
        idle_cycles(16);

        // Random gates, random start pulses, rare resets.
        for (int t = 0; t < 600; t++) begin
            gate_tt = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) gate_tt = 4'b0001;
            tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0));
        end
        idle_cycles(16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
